// File: rtl/fetch_issue.sv
// Instruction fetch/issue front end: owns the PC, drives a single-outstanding imem
// request/response interface and holds one issued instruction until decode takes it.
module fetch_issue #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [4:0]             if_opcode,
  output logic [PC_WIDTH-1:0]    if_pc_inc,
  output logic                   if_valid,
  output logic                   halted
);

  typedef enum logic [1:0] {StReq, StWait, StHalted} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   drop_q, drop_d;
  logic                   if_valid_q, if_valid_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0]    if_pc_inc_q, if_pc_inc_d;
  logic                   accept;
  logic                   consume;
  logic                   rsp_is_halt;

  // Only request when the output slot is guaranteed free by the time data returns.
  assign imem_req    = rst_n && (state_q == StReq) && (!if_valid_q || !stall);
  assign imem_addr   = pc_q;
  assign accept      = imem_req && imem_ready;
  assign consume     = if_valid_q && !stall;
  assign rsp_is_halt = (imem_rdata[INSTR_WIDTH-1 -: 5] == 5'b00000);

  assign if_instr  = if_instr_q;
  assign if_opcode = if_instr_q[INSTR_WIDTH-1 -: 5];
  assign if_pc_inc = if_pc_inc_q;
  assign if_valid  = if_valid_q;
  assign halted    = (state_q == StHalted);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_inc_d = if_pc_inc_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      unique case (state_q)
        StReq: begin
          if (accept) begin
            state_d = StWait;
            drop_d  = 1'b1;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = StReq;
      endcase
    end else begin
      if (consume) if_valid_d = 1'b0;
      unique case (state_q)
        StReq: begin
          if (accept) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + PC_WIDTH'(2);
            state_d    = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StReq;
            end else begin
              if_instr_d  = imem_rdata;
              if_pc_inc_d = fetch_pc_q + PC_WIDTH'(2);
              if_valid_d  = 1'b1;
              state_d     = rsp_is_halt ? StHalted : StReq;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StReq;
      pc_q        <= RESET_PC;
      fetch_pc_q  <= '0;
      drop_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= '0;
      if_pc_inc_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_inc_q <= if_pc_inc_d;
    end
  end

endmodule

// File: tb/tb_fetch_issue.sv
// Bench for fetch_issue: directed scenarios followed by random traffic, checked against a
// transaction-level model of the fetch front end and a variable-latency memory.
module tb_fetch_issue;

  logic        clk, rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_instr, if_pc_inc;
  logic [4:0]  if_opcode;
  logic        if_valid, halted;

  int vectors = 0;
  int fails   = 0;

  // Model: program counter, issued slot, and whether a fetch is in flight / wrong-path / stopped.
  logic [15:0] m_pc, m_fpc, m_instr, m_inc;
  logic        m_v, m_stop, m_fly, m_wrong;
  // Memory: one pending response with a countdown.
  logic        mem_busy;
  int          mem_cnt;
  logic [15:0] mem_data;

  fetch_issue #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_instr(if_instr), .if_opcode(if_opcode), .if_pc_inc(if_pc_inc),
    .if_valid(if_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_fpc = '0; m_instr = '0; m_inc = '0;
    m_v = 0; m_stop = 0; m_fly = 0; m_wrong = 0;
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance model on posedge.
  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc, input logic rdy,
                       input int lat, input logic [15:0] data, input logic spur);
    logic rv, exp_req, acc;
    logic [15:0] rdat;
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy;
    rv   = (mem_busy && mem_cnt == 0) || (!mem_busy && spur);
    rdat = mem_busy ? mem_data : data;
    imem_rvalid = rv; imem_rdata = rdat;
    #1;
    exp_req = !m_stop && !m_fly && (!m_v || !st);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, m_v);
    chk("if_instr", if_instr, m_instr);
    chk("if_opcode", if_opcode, m_instr[15:11]);
    chk("if_pc_inc", if_pc_inc, m_inc);
    chk("halted", halted, m_stop);
    acc = exp_req && rdy;
    @(posedge clk);
    if (mem_busy) begin
      if (mem_cnt == 0) mem_busy = 0;
      else mem_cnt--;
    end
    if (acc) begin
      mem_busy = 1; mem_cnt = lat - 1; mem_data = data;
    end
    if (rd) begin
      m_pc = rpc; m_v = 0;
      if (m_stop) m_stop = 0;
      else if (m_fly) begin
        if (rv) begin m_fly = 0; m_wrong = 0; end
        else m_wrong = 1;
      end else if (acc) begin
        m_fly = 1; m_wrong = 1;
      end
    end else begin
      if (m_v && !st) m_v = 0;
      if (m_fly && rv) begin
        m_fly = 0;
        if (m_wrong) m_wrong = 0;
        else begin
          m_v = 1; m_instr = rdat; m_inc = m_fpc + 16'd2;
          if (rdat[15:11] == 5'd0) m_stop = 1;
        end
      end else if (acc) begin
        m_fly = 1; m_fpc = m_pc; m_pc = m_pc + 16'd2;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] d;
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    mem_busy = 0; mem_cnt = 0; mem_data = '0;
    model_reset();
    #1;
    chk("reset_req", imem_req, 1'b0);
    chk("reset_valid", if_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;

    // Basic fetch
    cycle(0, 0, 16'h0, 1, 1, 16'h4001, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0000, 0);
    chk("basic_instr", if_instr, 16'h4001);
    chk("basic_opcode", if_opcode, 5'h08);
    chk("basic_pc_inc", if_pc_inc, 16'h0002);
    chk("basic_next_addr", imem_addr, 16'h0002);
    // Stall backpressure
    repeat (3) cycle(1, 0, 16'h0, 1, 1, 16'h1111, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h2222, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0, 0);
    // Redirect squash
    cycle(0, 0, 16'h0, 1, 2, 16'hDEAD, 0);
    cycle(0, 1, 16'h0100, 1, 1, 16'h0, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0, 0);
    chk("squash_valid", if_valid, 1'b0);
    chk("squash_addr", imem_addr, 16'h0100);
    // Halt
    cycle(0, 0, 16'h0, 1, 1, 16'h0000, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0, 0);
    chk("halt_flag", halted, 1'b1);
    repeat (10) cycle(1'($urandom % 2), 0, 16'h0, 1, 1, 16'h0, 1'($urandom % 2));
    cycle(0, 1, 16'h0200, 1, 1, 16'h0, 0);
    chk("unhalt_flag", halted, 1'b0);
    chk("unhalt_addr", imem_addr, 16'h0200);
    // Wrap and ready hold
    cycle(0, 1, 16'hFFFE, 0, 1, 16'h0, 0);
    repeat (2) begin
      cycle(0, 0, 16'h0, 0, 1, 16'h0, 0);
      chk("hold_addr", imem_addr, 16'hFFFE);
    end
    cycle(0, 0, 16'h0, 1, 1, 16'h1234, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0, 0);
    chk("wrap_pc_inc", if_pc_inc, 16'h0000);
    chk("wrap_addr", imem_addr, 16'h0000);
    // Async reset mid-WAIT, stale response afterwards
    cycle(0, 0, 16'h0, 1, 3, 16'h5555, 0);
    cycle(0, 0, 16'h0, 1, 1, 16'h0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_valid", if_valid, 1'b0);
    chk("async_req", imem_req, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (2) cycle(0, 0, 16'h0, 0, 1, 16'h0, 0);
    chk("post_reset_addr", imem_addr, 16'h0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      if ($urandom % 10 == 0) d[15:11] = 5'd0;
      cycle(1'($urandom % 4 == 0),
            1'(m_stop ? ($urandom % 4 == 0) : ($urandom % 16 == 0)),
            16'($urandom),
            1'($urandom % 3 != 0),
            int'($urandom_range(1, 4)),
            d,
            1'($urandom % 8 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
